// File: rtl/vram_arbiter_if.sv
// Port-A bus bundle between the two VRAM requesters, the arbiter and the RAM.
// slave = arbiter side, master = requester/RAM side.
interface vram_arbiter_if #(
    parameter int unsigned ADDRESS_WIDTH = 14,
    parameter int unsigned DATA_WIDTH    = 8
);
    logic                     cpu_req;
    logic                     cpu_we;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_din;
    logic [DATA_WIDTH-1:0]    cpu_dout;
    logic                     cpu_ack;

    logic                     ld_req;
    logic                     ld_we;
    logic [ADDRESS_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0]    ld_din;
    logic [DATA_WIDTH-1:0]    ld_dout;
    logic                     ld_ack;

    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_din;
    logic [DATA_WIDTH-1:0]    ram_dout;
    logic                     grant_ld;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        input  ld_req, ld_we, ld_addr, ld_din,
        output ld_dout, ld_ack,
        output ram_we, ram_addr, ram_din,
        input  ram_dout,
        output grant_ld
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        output ld_req, ld_we, ld_addr, ld_din,
        input  ld_dout, ld_ack,
        input  ram_we, ram_addr, ram_din,
        output ram_dout,
        input  grant_ld
    );
endinterface

// File: rtl/vram_arbiter.sv
// Arbitrates VRAM port A between the CPU (fixed priority) and the loader
// (starvation-bounded), hiding the RAM's one-cycle registered read latency.
module vram_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 14,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned MAX_WAIT      = 4
) (
    input  logic          clk,
    input  logic          resetn,
    vram_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic                     grant_ld_q, grant_ld_d;
    logic                     ram_we_q, ram_we_d;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]    ram_din_q, ram_din_d;
    logic                     cpu_ack_q, cpu_ack_d;
    logic                     ld_ack_q, ld_ack_d;
    logic [DATA_WIDTH-1:0]    cpu_dout_q, cpu_dout_d;
    logic [DATA_WIDTH-1:0]    ld_dout_q, ld_dout_d;

    logic arb_phase;
    logic ld_turn;
    logic grant_any;

    // Loader wins only when alone or once the CPU has used up its allowance.
    assign arb_phase = (state_q == S_IDLE) || (state_q == S_DONE);
    assign ld_turn   = bus.ld_req && (!bus.cpu_req || (wait_cnt_q == MAX_CNT));
    assign grant_any = arb_phase && (bus.cpu_req || bus.ld_req);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            grant_ld_q <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            cpu_ack_q  <= 1'b0;
            ld_ack_q   <= 1'b0;
            cpu_dout_q <= '0;
            ld_dout_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            grant_ld_q <= grant_ld_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            cpu_ack_q  <= cpu_ack_d;
            ld_ack_q   <= ld_ack_d;
            cpu_dout_q <= cpu_dout_d;
            ld_dout_q  <= ld_dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = grant_any ? S_ISSUE : S_IDLE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_DONE;
            S_DONE:  state_d = grant_any ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        grant_ld_d = grant_ld_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        cpu_ack_d  = 1'b0;
        ld_ack_d   = 1'b0;
        cpu_dout_d = cpu_dout_q;
        ld_dout_d  = ld_dout_q;

        if (arb_phase) begin
            if (!bus.ld_req || ld_turn) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != MAX_CNT) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        if (grant_any) begin
            grant_ld_d = ld_turn;
            ram_we_d   = ld_turn ? bus.ld_we   : bus.cpu_we;
            ram_addr_d = ld_turn ? bus.ld_addr : bus.cpu_addr;
            ram_din_d  = ld_turn ? bus.ld_din  : bus.cpu_din;
        end

        if (state_q == S_WAIT) begin
            if (grant_ld_q) begin
                ld_dout_d = bus.ram_dout;
                ld_ack_d  = 1'b1;
            end else begin
                cpu_dout_d = bus.ram_dout;
                cpu_ack_d  = 1'b1;
            end
        end
    end

    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.ld_ack   = ld_ack_q;
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.ld_dout  = ld_dout_q;
    assign bus.grant_ld = grant_ld_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural read-before-write VRAM
// model on port A.
module tb_vram_arbiter;
    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    vram_arbiter_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(8)) bus ();

    vram_arbiter #(.ADDRESS_WIDTH(14), .DATA_WIDTH(8), .MAX_WAIT(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [7:0] mem [0:16383];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ram_we"},   32'(bus.ram_we),   0);
        check({tag, ".ram_addr"}, 32'(bus.ram_addr), 0);
        check({tag, ".ram_din"},  32'(bus.ram_din),  0);
        check({tag, ".cpu_ack"},  32'(bus.cpu_ack),  0);
        check({tag, ".ld_ack"},   32'(bus.ld_ack),   0);
        check({tag, ".cpu_dout"}, 32'(bus.cpu_dout), 0);
        check({tag, ".ld_dout"},  32'(bus.ld_dout),  0);
        check({tag, ".grant_ld"}, 32'(bus.grant_ld), 0);
    endtask

    // One complete access by a single requester; checks latency, write-strobe width and ownership.
    task automatic access(input string tag, input bit ld, input bit we,
                          input logic [13:0] a, input logic [7:0] d, output logic [7:0] rd);
        int lat;
        int wes;
        int other;
        logic own;
        lat = 0; wes = 0; other = 0;
        if (ld) begin
            bus.ld_we = we; bus.ld_addr = a; bus.ld_din = d; bus.ld_req = 1'b1;
        end else begin
            bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_req = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (bus.ram_we) wes++;
            if (ld ? bus.cpu_ack : bus.ld_ack) other++;
            own = ld ? bus.ld_ack : bus.cpu_ack;
            if (own) break;
        end
        rd = ld ? bus.ld_dout : bus.cpu_dout;
        check({tag, ".grant_ld"}, 32'(bus.grant_ld), 32'(ld));
        bus.cpu_req = 1'b0;
        bus.ld_req  = 1'b0;
        check({tag, ".latency"},   32'(lat),   3);
        check({tag, ".we_cycles"}, 32'(wes),   we ? 1 : 0);
        check({tag, ".other_ack"}, 32'(other), 0);
        tick();
        check({tag, ".ack_drop"}, 32'(ld ? bus.ld_ack : bus.cpu_ack), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;
        int cpu_t, ld_t, n, last, perr, gerr, dual, noack, first, second;
        logic [7:0]  d1, d2;
        logic [13:0] a2;
        logic        exp_ld;

        resetn = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_din  = '0;
        #1;
        check_all_zero("reset");
        tick();
        resetn = 1'b1;
        tick();

        // CPU write then read
        access("cpu_wr", 1'b0, 1'b1, 14'h0123, 8'h5A, rd);
        access("cpu_rd", 1'b0, 1'b0, 14'h0123, 8'h00, rd);
        check("cpu_rd.data", 32'(rd), 32'h5A);
        check("cpu_rd.ld_dout_kept", 32'(bus.ld_dout), 0);

        // Loader alone
        access("ld_wr", 1'b1, 1'b1, 14'h3FFF, 8'hC3, rd);
        access("ld_rd", 1'b1, 1'b0, 14'h3FFF, 8'h00, rd);
        check("ld_rd.data", 32'(rd), 32'hC3);
        check("ld_rd.cpu_dout_kept", 32'(bus.cpu_dout), 32'h5A);

        // Simultaneous requests, CPU drops after its ack
        cpu_t = 0; ld_t = 0;
        bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0123;
        bus.ld_we  = 1'b0; bus.ld_addr  = 14'h3FFF;
        bus.cpu_req = 1'b1; bus.ld_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.cpu_ack) begin cpu_t = c; bus.cpu_req = 1'b0; end
            if (bus.ld_ack) begin ld_t = c; bus.ld_req = 1'b0; break; end
        end
        bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
        check("simul.cpu_ack_t", 32'(cpu_t), 3);
        check("simul.ld_ack_t",  32'(ld_t),  6);
        check("simul.cpu_dout",  32'(bus.cpu_dout), 32'h5A);
        check("simul.ld_dout",   32'(bus.ld_dout),  32'hC3);
        tick();

        // Both requesting continuously for 30 accesses
        n = 0; last = 0; perr = 0; gerr = 0; dual = 0;
        bus.cpu_req = 1'b1; bus.ld_req = 1'b1;
        for (int c = 1; c <= 200 && n < 30; c++) begin
            tick();
            if (bus.cpu_ack && bus.ld_ack) dual++;
            if (bus.cpu_ack || bus.ld_ack) begin
                exp_ld = ((n % 5) == 4);
                if (bus.ld_ack !== exp_ld) perr++;
                if (exp_ld ? (bus.ld_dout !== 8'hC3) : (bus.cpu_dout !== 8'h5A)) perr++;
                if (c - last != 3) gerr++;
                last = c;
                n++;
                if (n == 30) begin bus.cpu_req = 1'b0; bus.ld_req = 1'b0; end
            end
        end
        bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
        check("stream.acks",   32'(n),    30);
        check("stream.order",  32'(perr), 0);
        check("stream.gaps",   32'(gerr), 0);
        check("stream.dual",   32'(dual), 0);
        noack = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.cpu_ack || bus.ld_ack) noack++;
        end
        check("stream.quiet", 32'(noack), 0);

        // Reset during ISSUE of a CPU write
        access("pre_wr", 1'b0, 1'b1, 14'h0010, 8'h77, rd);
        bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0010; bus.cpu_din = 8'hEE; bus.cpu_req = 1'b1;
        tick();
        check("rst_mid.issue_we", 32'(bus.ram_we), 1);
        resetn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        bus.cpu_req = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        noack = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.cpu_ack || bus.ld_ack) noack++;
        end
        check("rst_mid.no_ack", 32'(noack), 0);
        access("rst_rd", 1'b0, 1'b0, 14'h0010, 8'h00, rd);
        check("rst_rd.old_data", 32'(rd), 32'h77);

        // Request held through ack with a new address
        access("hold_wr0", 1'b0, 1'b1, 14'h0200, 8'h11, rd);
        access("hold_wr1", 1'b0, 1'b1, 14'h0201, 8'h22, rd);
        first = 0; second = 0; d1 = '0; d2 = '0; a2 = '0;
        bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0200; bus.cpu_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (first != 0 && c == first + 1) a2 = bus.ram_addr;
            if (bus.cpu_ack) begin
                if (first == 0) begin
                    first = c; d1 = bus.cpu_dout; bus.cpu_addr = 14'h0201;
                end else begin
                    second = c; d2 = bus.cpu_dout; bus.cpu_req = 1'b0;
                    break;
                end
            end
        end
        bus.cpu_req = 1'b0;
        check("hold.first_t",  32'(first),  3);
        check("hold.second_t", 32'(second), 6);
        check("hold.d1",       32'(d1),     32'h11);
        check("hold.d2",       32'(d2),     32'h22);
        check("hold.addr2",    32'(a2),     32'h0201);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single read/write port (port A) of the dual-port video RAM between two requesters: the Z80 CPU bus and the ROM/snapshot loader. Fixed CPU priority, plus a starvation bound so the loader always progresses. The port-B video read path is not touched. Each access uses a level request / single-cycle acknowledge handshake, and the RAM's one-cycle registered read latency is absorbed internally.

## Interface
Parameters:
- ADDRESS_WIDTH, 14, RAM word address width
- DATA_WIDTH, 8, RAM word width
- MAX_WAIT, 4, max consecutive CPU grants while loader is pending (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDRESS_WIDTH  CPU address
- cpu_din  in  DATA_WIDTH  CPU write data
- cpu_dout  out  DATA_WIDTH  CPU read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- ld_req, ld_we, ld_addr, ld_din, ld_dout, ld_ack: loader equivalents of the cpu_* ports, same widths
- ram_we  out  1  to RAM we_a
- ram_addr  out  ADDRESS_WIDTH  to RAM addr_a
- ram_din  out  DATA_WIDTH  to RAM din_a
- ram_dout  in  DATA_WIDTH  from RAM dout_a (registered, 1-cycle latency)
- grant_ld  out  1  1 while the current/last access belongs to the loader

## Operation
- FSM states:
  - IDLE: arbitrate; on grant go to ISSUE.
  - ISSUE: ram_* held for one cycle; next state WAIT.
  - WAIT: ram_we=0; next state DONE.
  - DONE: ack/dout driven for the owner; arbitrate as in IDLE, so a grant goes to ISSUE and no request goes to IDLE.
- All outputs are registered.
- Arbitration runs at an edge in IDLE or DONE:
  - Both requests present: loader wins if wait_cnt == MAX_WAIT, else CPU wins.
  - Only one request present: that requester wins.
- Grant latches requester, we, addr, din into ram_we/ram_addr/ram_din; grant_ld updates.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - Increments, saturating at MAX_WAIT, on each CPU grant while ld_req=1.
  - Clears on a loader grant or at any arbitration edge with ld_req=0.
- Requester handshake:
  - Hold we/addr/din stable from asserting req until its ack.
  - Req still high at the edge ending the ack cycle requests a further access. To stop, drop req in the ack cycle.
- Read data: ram_dout sampled at the WAIT→DONE edge into the owner's dout. The non-owner dout keeps its old value.
- Write: the RAM writes at the ISSUE→WAIT edge. dout is still updated, with RAM read-before-write data, and is don't-care to the requester.
- ram_we never asserts outside ISSUE. ram_addr/ram_din hold their last value outside ISSUE.

## Timing
- Reset (resetn=0, async): state IDLE; wait_cnt 0; and all outputs 0 immediately: ram_we, ram_addr, ram_din, cpu_ack, ld_ack, cpu_dout, ld_dout, grant_ld.
- Reset mid-access: ram_we drops immediately. A write whose ISSUE→WAIT edge has not occurred is lost. No ack is issued. Requesters must re-request after release.
- Latency: req high before edge E0 (IDLE) → ram_we/addr valid after E0 → RAM acts at E1 → ack=1 and dout valid for exactly the cycle after E2.
- Throughput: back-to-back accesses every 3 cycles (DONE→ISSUE), for the same or the other requester.
- Starvation bound: with both requesters continuously requesting, pattern is MAX_WAIT CPU accesses then 1 loader access. The loader waits at most (MAX_WAIT+1)×3 cycles from entering arbitration.
- Simultaneous: both requests first seen at the same edge with wait_cnt=0 → CPU granted, wait_cnt=1.
- Req dropped before grant: no access and no ack. Req dropped after grant: the access completes and ack still pulses.

## Test plan
- CPU write 0x5A to 0x0123, then read 0x0123 → ram_we high exactly 1 cycle; cpu_ack pulses 3 edges after req; cpu_dout=0x5A; ld_ack never asserts.
- Loader alone writes 0x3FFF=0xC3 and reads it back → grant_ld=1, ld_dout=0xC3, cpu_dout unchanged.
- cpu_req and ld_req rise together (MAX_WAIT=4), CPU req dropped after first ack → CPU access first, loader ack 3 cycles after cpu_ack.
- Both requests held high continuously for 30 accesses → acks follow CPU×4, LD×1 repeating; no two acks in the same cycle; acks exactly 3 cycles apart.
- Assert resetn=0 during ISSUE of a CPU write to 0x0010 → ram_we and all outputs 0 immediately; no ack; readback after reset shows the old value.
- Req held high through ack with changed addr → second access starts at DONE edge to the new address, ack 3 cycles after the first.
